shift_add_mul4: RTL and testbench
=================================

SHIFT_ADD_MUL4 -- requirements
Module: shift_add_mul4

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: WIDTH, 4, operand width; product width is 2*WIDTH.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-006 Port: a  input  WIDTH  multiplicand, unsigned; captured when start is accepted.
REQ-007 Port: b  input  WIDTH  multiplier, unsigned; captured when start is accepted.
REQ-008 Port: busy  output  1  high in RUN and DONE states.
REQ-009 Port: done  output  1  one-cycle pulse, high only in DONE state.
REQ-010 Port: p  output  2*WIDTH  registered product of the last completed multiply.

Function
REQ-011 FSM SHALL have states IDLE, RUN, DONE; all outputs registered or decoded from state only.
REQ-012 IDLE: start=1 at an edge SHALL latch A<=a, P<={WIDTH zeros, b}, cnt<=0, next RUN; start=0 stays IDLE.
REQ-013 RUN, each cycle: if P[0]=1, {c,sum} = P[2W-1:W] + A (WIDTH-bit add, carry-in 0, carry-out c); else {c,sum} = {0, P[2W-1:W]}.
REQ-014 RUN, each edge: P <= {c, sum, P[W-1:1]} (right shift by one with carry into MSB); cnt <= cnt+1.
REQ-015 RUN SHALL last exactly WIDTH cycles; on the edge where cnt = WIDTH-1, p <= updated P value, next DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1, then next IDLE.
REQ-017 Latency: start high in cycle N -> RUN in cycles N+1..N+WIDTH -> done=1 and p valid in cycle N+WIDTH+1 -> IDLE in N+WIDTH+2.
REQ-018 start while busy=1 (RUN or DONE) SHALL be ignored; no queuing; a and b changes while busy SHALL NOT affect the result.
REQ-019 p SHALL change only on the RUN->DONE edge and on reset; it holds its value through IDLE and the next RUN.
REQ-020 Arithmetic SHALL be exact unsigned: p = a*b for all 2^(2*WIDTH) operand pairs; no overflow is possible.
REQ-021 Operand zero SHALL still take the full WIDTH RUN cycles (no early termination).
REQ-022 cnt SHALL be ceil(log2(WIDTH))+1 bits wide minimum so WIDTH-1 is representable without wrap.

Reset
REQ-023 reset=1 at an edge SHALL force state IDLE, busy=0, done=0, p=0, A=0, P=0, cnt=0, regardless of state.
REQ-024 reset SHALL take priority over start on the same edge.
REQ-025 reset mid-RUN SHALL abandon the operation with no done pulse; first start after reset release is accepted normally.

Verification
REQ-026 a=15, b=15, start 1 cycle -> busy for 5 cycles, done=1 in cycle N+5, p=0xE1 (225).
REQ-027 a=13, b=11 -> p=0x8F (143) in done cycle; a=0, b=9 -> p=0x00 after full 4 RUN cycles.
REQ-028 start held high continuously from cycle N -> products complete at N+5, N+11, N+17 (start during RUN/DONE ignored, re-accepted in IDLE).
REQ-029 a=7,b=6 started, then a/b changed to 15/15 and start pulsed during RUN -> p=0x2A (42), single done pulse.
REQ-030 a=9,b=9 started, reset asserted in 2nd RUN cycle -> next cycle busy=0, done=0, p=0; no done pulse follows.
REQ-031 Exhaustive sweep of all 256 (a,b) pairs with WIDTH=4 -> each done-cycle p equals a*b.

Source files
------------

// File: rtl/shift_add_mul4.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mul4
// Purpose  : Sequential unsigned multiplier using the classic shift-and-add
//            algorithm. One operand bit is consumed per RUN cycle, so a
//            multiply takes exactly WIDTH RUN cycles plus one DONE cycle.
// Ports    :
//   clk    in   1        rising-edge clock for all state
//   reset  in   1        synchronous active-high reset
//   start  in   1        begin a multiply (honoured only while idle)
//   a      in   WIDTH    multiplicand, unsigned, captured on accept
//   b      in   WIDTH    multiplier, unsigned, captured on accept
//   busy   out  1        high while in RUN or DONE
//   done   out  1        single-cycle pulse while in DONE
//   p      out  2*WIDTH  product of the last completed multiply
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_mul4 #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  // One extra bit beyond log2 keeps WIDTH-1 representable for any WIDTH.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [WIDTH-1:0]     mcand;      // captured multiplicand
  logic [2*WIDTH-1:0]   acc;        // {partial product, remaining multiplier bits}
  logic [CNT_W-1:0]     cnt;        // RUN step counter
  logic [2*WIDTH-1:0]   prod_q;     // product register driving p

  logic [WIDTH:0]       partial;    // {carry, sum} of the upper half step
  logic [2*WIDTH-1:0]   acc_shifted;
  logic                 last_step;

  // --------------------------------------------------------------------------
  // Datapath step: conditionally add the multiplicand into the upper half,
  // then shift the whole accumulator right, pushing the carry into the MSB.
  // The low half gradually fills with product bits while the multiplier bits
  // are shifted out of the bottom.
  // --------------------------------------------------------------------------
  always_comb begin
    partial     = '0;
    acc_shifted = '0;
    if (acc[0]) begin
      partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    end else begin
      partial = {1'b0, acc[2*WIDTH-1:WIDTH]};
    end
    acc_shifted = {partial, acc[WIDTH-1:1]};
  end

  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. start is only looked at in IDLE, so requests made while
  // busy are dropped rather than queued.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers. Operands are sampled only on accept, so a/b may change
  // freely during RUN/DONE without disturbing the running multiply.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      acc    <= '0;
      cnt    <= '0;
      prod_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= acc_shifted;
          cnt <= cnt + 1'b1;
          // The product register only moves on the RUN->DONE edge, so p
          // holds the previous result through IDLE and the next RUN.
          if (last_step) begin
            prod_q <= acc_shifted;
          end
        end
        default: begin
          // DONE: hold everything
        end
      endcase
    end
  end

  // Outputs are decoded from the state register only (no input paths).
  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);
  assign p    = prod_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mul4.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_mul4
// Purpose  : Self-checking bench for shift_add_mul4. A cycle-level reference
//            model derived from the block's timing rules (accept in idle, busy
//            for WIDTH+1 cycles, done in the last of them) pushes the exact
//            product a*b into a scoreboard queue on every accepted start; a
//            monitor on the falling edge pops and compares on each done pulse
//            and also checks busy/done/p against the model every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_mul4;

  localparam int WIDTH = 4;
  localparam int PW    = 2 * WIDTH;

  logic          clk;
  logic          reset;
  logic          start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic          busy;
  logic          done;
  logic [PW-1:0] p;

  int checks;
  int failures;
  bit chk_en;

  // Reference model state
  int            m_cnt;   // busy cycles remaining (0 = idle)
  logic [PW-1:0] m_job;   // product of the job in flight
  logic [PW-1:0] m_p;     // value p must currently show
  logic [PW-1:0] sb_q[$]; // scoreboard of expected products

  shift_add_mul4 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: advanced on every rising edge from the driven inputs.
  initial begin
    m_cnt = 0;
    m_job = '0;
    m_p   = '0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0;
      m_p   = '0;
      sb_q.delete();
    end else if (m_cnt == 0) begin
      if (start) begin
        m_job = PW'({4'd0, a} * {4'd0, b});
        sb_q.push_back(m_job);
        m_cnt = WIDTH + 1;
      end
    end else begin
      if (m_cnt == 2) m_p = m_job;  // entering the done cycle
      m_cnt = m_cnt - 1;
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (busy !== (m_cnt != 0)) begin
        failures++;
        $display("FAIL busy t=%0t actual=%b required=%b", $time, busy, (m_cnt != 0));
      end
      checks++;
      if (done !== (m_cnt == 1)) begin
        failures++;
        $display("FAIL done t=%0t actual=%b required=%b", $time, done, (m_cnt == 1));
      end
      checks++;
      if (p !== m_p) begin
        failures++;
        $display("FAIL p_hold t=%0t actual=%0d required=%0d", $time, p, m_p);
      end
      if (done === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_done t=%0t actual_p=%0d required=no_done", $time, p);
        end else begin
          logic [PW-1:0] exp;
          exp = sb_q.pop_front();
          if (p !== exp) begin
            failures++;
            $display("FAIL sb_product t=%0t actual=%0d required=%0d", $time, p, exp);
          end
        end
      end
    end
  end

  // One clock of stimulus, applied just after the rising edge.
  task automatic cyc(input logic s, input logic [WIDTH-1:0] aa,
                     input logic [WIDTH-1:0] bb, input logic r);
    start = s;
    a     = aa;
    b     = bb;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with random operand noise until the model is idle.
  task automatic wait_idle();
    for (int g = 0; g < 20 && m_cnt != 0; g++) begin
      cyc(1'($urandom), 4'($urandom), 4'($urandom), 1'b0);
    end
  endtask

  // Issue one multiply; during busy cycles start/a/b are randomised and must
  // have no effect.
  task automatic run_job(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
    wait_idle();
    cyc(1'b1, aa, bb, 1'b0);
    for (int k = 0; k < WIDTH; k++) begin
      cyc(1'($urandom), 4'($urandom), 4'($urandom), 1'b0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;                 // reset state checked from here on
    cyc(1'b0, '0, '0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0);

    // Directed products
    run_job(4'd15, 4'd15);         // 225
    run_job(4'd13, 4'd11);         // 143
    run_job(4'd0,  4'd9);          // 0, still full length
    run_job(4'd9,  4'd0);
    run_job(4'd1,  4'd1);

    // Operands and start disturbed during RUN
    wait_idle();
    cyc(1'b1, 4'd7, 4'd6, 1'b0);
    cyc(1'b1, 4'd15, 4'd15, 1'b0);
    cyc(1'b1, 4'd15, 4'd15, 1'b0);
    cyc(1'b0, 4'd15, 4'd15, 1'b0);
    cyc(1'b1, 4'd15, 4'd15, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b0);

    // Start held high continuously: back-to-back jobs every WIDTH+2 cycles
    wait_idle();
    for (int k = 0; k < 18; k++) cyc(1'b1, 4'd12, 4'd10, 1'b0);
    cyc(1'b0, '0, '0, 1'b0);

    // Reset in the second RUN cycle abandons the job
    wait_idle();
    cyc(1'b1, 4'd9, 4'd9, 1'b0);   // accepted at this edge
    cyc(1'b0, 4'd9, 4'd9, 1'b0);   // first RUN cycle
    cyc(1'b1, 4'd9, 4'd9, 1'b1);   // second RUN cycle: reset beats start
    for (int k = 0; k < 6; k++) cyc(1'b0, '0, '0, 1'b0);
    run_job(4'd3, 4'd5);           // first start after reset is honoured

    // Reset together with start while idle: start must be dropped
    cyc(1'b1, 4'd8, 4'd8, 1'b1);
    cyc(1'b0, '0, '0, 1'b0);

    // Exhaustive sweep of all operand pairs
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_job(4'(i), 4'(j));
      end
    end

    // Random traffic with random start density and occasional reset
    for (int k = 0; k < 600; k++) begin
      cyc(1'($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom),
          ($urandom_range(0, 63) == 0));
    end

    cyc(1'b0, '0, '0, 1'b0);
    wait_idle();
    cyc(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover actual=%0d required=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
